test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
Synthesizable controller that runs a set of per-module test harnesses one at a time and folds their verdicts into a single pass/fail result. It drives each harness's start line, waits for the harness's done/passed handshake, and enforces a cycle timeout. It sits directly upstream of the per-module harnesses (data memory, register file, ALU, ...) and replaces the ad-hoc top-level start/wait logic.

Parameters:
NUM_TESTS, 4, number of attached harnesses (1..16)
TIMEOUT, 1000, max clk cycles to wait for a harness's done rising edge
IDX_W, 4, width of test index (ceil(log2(NUM_TESTS)), min 1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
go  input  1  request a full test run; sampled only in IDLE
startTests  output  NUM_TESTS  one-hot start level to harness i
testDone  input  NUM_TESTS  done flag from harness i
dutPassed  input  NUM_TESTS  pass flag from harness i, valid when testDone[i] rises
busy  output  1  high from the cycle after go is accepted until FINISH
curTest  output  IDX_W  index of harness currently running
passVector  output  NUM_TESTS  per-harness recorded pass bit
timedOut  output  NUM_TESTS  per-harness timeout flag
allDone  output  1  high in FINISH, held until next accepted go
allPassed  output  1  AND of passVector, valid when allDone=1, else 0

Behaviour:
- Reset (async, any state): state=IDLE; startTests=0, busy=0, curTest=0, passVector=0, timedOut=0, allDone=0, allPassed=0, timeout counter=0, edge-detect registers=0.
- States: IDLE, LAUNCH, WAIT, RECORD, FINISH.
- IDLE: go=1 -> clear passVector, timedOut, allDone; curTest=0; -> LAUNCH. go=0 -> stay.
- LAUNCH (1 cycle): startTests[curTest]=1 (registered; stays high through WAIT); counter=0; -> WAIT.
- WAIT: testDone[curTest] is rising-edge detected against a 1-cycle delayed copy. On the rising edge, latch dutPassed[curTest] into passVector[curTest] -> RECORD. Otherwise counter++; when counter reaches TIMEOUT-1 with no edge, set timedOut[curTest]=1, passVector[curTest]=0 -> RECORD.
- Rising edge and timeout in the same cycle: the edge wins (pass bit recorded, timedOut stays 0).
- testDone already high on entry to WAIT: the delayed copy is reset to 0 in LAUNCH, so it counts as an edge on the first WAIT cycle.
- Done edges on non-current indices are ignored.
- RECORD (1 cycle): startTests[curTest]=0. If curTest==NUM_TESTS-1 -> FINISH; else curTest++ -> LAUNCH.
- FINISH: allDone=1, busy=0, allPassed=&passVector. go=1 -> behave as IDLE accept (restart); else hold.
- busy=1 in LAUNCH, WAIT, RECORD.
- At most one startTests bit is high at any time.
- go while busy is ignored.
- Latency with no timeout: harness i starts exactly 2 cycles after the previous harness's done edge (RECORD, LAUNCH).
- Counter width is ceil(log2(TIMEOUT))+1. It saturates and never wraps.
- Reset mid-run drops startTests immediately and discards partial results.

Test Plan:
- NUM_TESTS=4, all harnesses raise done+passed 5 cycles after start, go pulse -> startTests walks 0001,0010,0100,1000; passVector=1111; allDone=1, allPassed=1; total run 4*(1+6+1) cycles ±1.
- Harness 2 reports dutPassed=0 -> passVector=1011, allPassed=0, timedOut=0000.
- TIMEOUT=20, harness 1 never raises done -> timedOut=0010 exactly 20 cycles after LAUNCH; sequencing continues to harness 2 and 3; allPassed=0.
- Harness 0 holds testDone=1 before start, harness 3 toggles done while harness 1 runs -> harness 0 is recorded on the first WAIT cycle; the stray harness 3 edge has no effect on passVector[3] until its own run.
- Assert reset during WAIT of harness 2 -> all outputs 0 in the same cycle (async); a following go restarts at curTest=0.
- go pulses while busy are ignored; go in FINISH -> allDone clears and the run restarts with passVector cleared.

Source files
------------

// File: rtl/test_sequencer.sv
// Runs attached test harnesses one at a time, enforces a per-harness cycle timeout,
// and folds the individual verdicts into a single pass/fail result.
module test_sequencer #(
    parameter int unsigned NUM_TESTS = 4,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    output logic [NUM_TESTS-1:0] startTests,
    input  logic [NUM_TESTS-1:0] testDone,
    input  logic [NUM_TESTS-1:0] dutPassed,
    output logic                 busy,
    output logic [IDX_W-1:0]     curTest,
    output logic [NUM_TESTS-1:0] passVector,
    output logic [NUM_TESTS-1:0] timedOut,
    output logic                 allDone,
    output logic                 allPassed
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RECORD,
        FINISH
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 done_d;
    logic [NUM_TESTS-1:0] sel;
    logic                 cur_done;
    logic                 cur_pass;
    logic                 done_rise;

    // One-hot select of the running harness; done/pass of other harnesses never reach the FSM.
    assign sel       = NUM_TESTS'(1) << curTest;
    assign cur_done  = |(testDone & sel);
    assign cur_pass  = |(dutPassed & sel);
    assign done_rise = cur_done & ~done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            startTests <= '0;
            busy       <= 1'b0;
            curTest    <= '0;
            passVector <= '0;
            timedOut   <= '0;
            allDone    <= 1'b0;
            allPassed  <= 1'b0;
            count      <= '0;
            done_d     <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (go) begin
                        passVector <= '0;
                        timedOut   <= '0;
                        allDone    <= 1'b0;
                        allPassed  <= 1'b0;
                        curTest    <= '0;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    startTests <= sel;
                    count      <= '0;
                    // Cleared so a done already high on entry is seen as an edge.
                    done_d     <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    done_d <= cur_done;
                    if (done_rise) begin
                        passVector <= cur_pass ? (passVector | sel) : (passVector & ~sel);
                        state      <= RECORD;
                    end else if (count == CNT_LAST) begin
                        timedOut   <= timedOut | sel;
                        passVector <= passVector & ~sel;
                        state      <= RECORD;
                    end else if (count != '1) begin
                        count <= count + CNT_W'(1);
                    end
                end
                RECORD: begin
                    startTests <= '0;
                    if (curTest == IDX_LAST) begin
                        allDone   <= 1'b1;
                        busy      <= 1'b0;
                        allPassed <= &passVector;
                        state     <= FINISH;
                    end else begin
                        curTest <= curTest + IDX_W'(1);
                        state   <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: behavioural harness models, a run-level
// reference model, and a monitor that checks each harness launch and each run result.
module tb_test_sequencer;

    localparam int unsigned NT = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [NT-1:0] startTests;
    logic [NT-1:0] testDone;
    logic [NT-1:0] dutPassed;
    logic          busy;
    logic [IW-1:0] curTest;
    logic [NT-1:0] passVector;
    logic [NT-1:0] timedOut;
    logic          allDone;
    logic          allPassed;

    test_sequencer #(.NUM_TESTS(NT), .TIMEOUT(TO), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .startTests (startTests),
        .testDone   (testDone),
        .dutPassed  (dutPassed),
        .busy       (busy),
        .curTest    (curTest),
        .passVector (passVector),
        .timedOut   (timedOut),
        .allDone    (allDone),
        .allPassed  (allPassed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm, input string what);
        n_checks++;
        $display("FAIL %s: %s (t=%0t)", nm, what, $time);
    endtask

    // Harness i raises done dly[i] cycles after it sees its start (0 = never).
    // pre0: harness 0 holds done high permanently; stray3: harness 3 toggles done while harness 1 runs.
    int dly[NT];
    bit pas[NT];
    bit pre0   = 1'b0;
    bit stray3 = 1'b0;
    int hcnt[NT];

    initial begin
        testDone  = '0;
        dutPassed = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NT; i++) begin
                hcnt[i]      = startTests[i] ? hcnt[i] + 1 : 0;
                testDone[i]  = startTests[i] && dly[i] != 0 && hcnt[i] >= dly[i];
                dutPassed[i] = pas[i];
            end
            if (pre0) testDone[0] = 1'b1;
            if (stray3 && startTests[1]) testDone[3] = cyc[0];
        end
    end

    // Run-level reference: a harness is recorded if its done arrives within TO waiting
    // cycles (edge on the last waiting cycle still counts); each harness costs
    // launch + waiting cycles + record.
    function automatic void model(output logic [NT-1:0] pv, output logic [NT-1:0] to,
                                  output logic ap, output int cycles);
        pv = '0;
        to = '0;
        cycles = 0;
        for (int i = 0; i < NT; i++) begin
            int wait_cycles;
            bit responds;
            if (i == 0 && pre0) begin
                responds = 1'b1;
                wait_cycles = 1;
            end else begin
                responds = dly[i] != 0 && dly[i] <= int'(TO);
                wait_cycles = responds ? dly[i] : int'(TO);
            end
            if (responds) pv[i] = pas[i];
            else          to[i] = 1'b1;
            cycles += 1 + wait_cycles + 1;
        end
        ap = &pv;
    endfunction

    typedef struct {
        logic [NT-1:0] st;
        logic [IW-1:0] idx;
    } st_exp_t;

    typedef struct {
        logic [NT-1:0] pv;
        logic [NT-1:0] to;
        logic          ap;
        int            cycles;
        int            t0;
    } res_t;

    st_exp_t sq[$];
    res_t    rq[$];

    logic [NT-1:0] mon_prev_st = '0;
    logic          mon_prev_ad = 1'b0;
    st_exp_t       mon_se;
    res_t          mon_rr;

    // Monitor: every new start bit and every allDone rise is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (startTests != mon_prev_st && startTests != '0) begin
                if (sq.size() == 0) begin
                    fail_now("unexpected_start", $sformatf("startTests=%b with nothing expected", startTests));
                end else begin
                    mon_se = sq.pop_front();
                    chk("startTests", 32'(startTests), 32'(mon_se.st));
                    chk("curTest", 32'(curTest), 32'(mon_se.idx));
                end
            end
            if (allDone && !mon_prev_ad) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_allDone", "allDone rose with no run expected");
                end else begin
                    mon_rr = rq.pop_front();
                    chk("passVector", 32'(passVector), 32'(mon_rr.pv));
                    chk("timedOut", 32'(timedOut), 32'(mon_rr.to));
                    chk("allPassed", 32'(allPassed), 32'(mon_rr.ap));
                    chk("run_cycles", 32'(cyc - mon_rr.t0), 32'(mon_rr.cycles));
                end
            end
            mon_prev_st = startTests;
            mon_prev_ad = allDone;
        end
    end

    task automatic do_run(input bit pulse_busy);
        logic [NT-1:0] pv;
        logic [NT-1:0] to;
        logic          ap;
        int            cycles;
        int            w;
        res_t          r;
        model(pv, to, ap, cycles);
        for (int i = 0; i < NT; i++) sq.push_back('{st: NT'(1) << i, idx: IW'(i)});
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        r = '{pv: pv, to: to, ap: ap, cycles: cycles, t0: cyc};
        rq.push_back(r);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_allDone", 32'(allDone), 32'd0);
        chk("accept_passVector", 32'(passVector), 32'd0);
        if (pulse_busy) begin
            repeat (3) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        w = 0;
        while (!allDone && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!allDone) fail_now("run_timeout", "allDone=0 after 1000 cycles, expected 1");
        repeat (3) @(negedge clk);
        chk("finish_allDone", 32'(allDone), 32'd1);
        chk("finish_busy", 32'(busy), 32'd0);
        chk("finish_startTests", 32'(startTests), 32'd0);
    endtask

    task automatic set_all(input int d, input bit p);
        for (int i = 0; i < NT; i++) begin
            dly[i] = d;
            pas[i] = p;
        end
    endtask

    initial begin
        int w;
        reset = 1'b1;
        go    = 1'b0;
        set_all(6, 1'b1);
        @(negedge clk);
        chk("reset_startTests", 32'(startTests), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_allDone", 32'(allDone), 32'd0);
        chk("reset_passVector", 32'(passVector), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Every harness answers on its 6th started cycle: 4 * (1 + 6 + 1) cycles.
        do_run(1'b0);
        pas[2] = 1'b0;
        do_run(1'b1);
        set_all(6, 1'b1);
        dly[1] = 0;
        do_run(1'b0);
        set_all(4, 1'b1);
        pre0   = 1'b1;
        stray3 = 1'b1;
        do_run(1'b0);
        pre0   = 1'b0;
        stray3 = 1'b0;
        set_all(3, 1'b1);
        dly[0] = int'(TO);
        dly[1] = int'(TO) + 1;
        do_run(1'b0);

        // Asynchronous reset while harness 2 is waiting.
        set_all(3, 1'b1);
        dly[2] = 0;
        for (int i = 0; i < NT; i++) sq.push_back('{st: NT'(1) << i, idx: IW'(i)});
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        w = 0;
        while (startTests != 4'b0100 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (startTests != 4'b0100) fail_now("reach_harness2", "harness 2 never started");
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun_startTests", 32'(startTests), 32'd0);
        chk("midrun_busy", 32'(busy), 32'd0);
        chk("midrun_curTest", 32'(curTest), 32'd0);
        chk("midrun_passVector", 32'(passVector), 32'd0);
        chk("midrun_timedOut", 32'(timedOut), 32'd0);
        chk("midrun_allDone", 32'(allDone), 32'd0);
        chk("midrun_allPassed", 32'(allPassed), 32'd0);
        sq.delete();
        rq.delete();
        @(negedge clk);
        reset = 1'b0;
        set_all(5, 1'b1);
        do_run(1'b0);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NT; i++) begin
                case ($urandom_range(0, 9))
                    0:       dly[i] = 0;
                    1:       dly[i] = int'(TO);
                    2:       dly[i] = int'(TO) + 1;
                    default: dly[i] = int'($urandom_range(1, 8));
                endcase
                pas[i] = ($urandom_range(0, 3) != 0);
            end
            pre0   = ($urandom_range(0, 3) == 0);
            stray3 = $urandom_range(0, 1) == 1;
            do_run($urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
